// File: rtl/sd_xfer_pkg.sv
// Shared definitions for the SD data transfer sequencer.
package sd_xfer_pkg;

  // Block-level sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_XFER,
    ST_BUSY_WAIT,
    ST_NEXT,
    ST_STOP,
    ST_FIN
  } xfer_state_e;

  // PHY start codes.
  localparam logic [1:0] SD_START_NONE = 2'b00;
  localparam logic [1:0] SD_START_WR   = 2'b01;
  localparam logic [1:0] SD_START_RD   = 2'b10;
  localparam logic [1:0] SD_START_STOP = 2'b11;

  // CRC status token reported by the card for an accepted write block.
  localparam logic [2:0] SD_TOKEN_OK = 3'b010;

  // Error vector layout: {timeout, crc, token}.
  localparam int ERR_W     = 3;
  localparam int ERR_TOKEN = 0;
  localparam int ERR_CRC   = 1;
  localparam int ERR_TMO   = 2;

endpackage

// File: rtl/sd_data_xfer_ctrl_if.sv
// Host register block <-> transfer sequencer request/status bundle.
interface sd_data_xfer_ctrl_if #(
  parameter int BLK_CNT_W = 8
);
  import sd_xfer_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_dir;
  logic [BLK_CNT_W-1:0] req_blocks;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic [ERR_W-1:0]     err;
  logic [BLK_CNT_W-1:0] blocks_done;

  // Register block side.
  modport master (
    output req_valid, req_dir, req_blocks, abort,
    input  req_ready, busy, done, err, blocks_done
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_dir, req_blocks, abort,
    output req_ready, busy, done, err, blocks_done
  );

endinterface

// File: rtl/sd_xfer_timeout.sv
// Loadable down-counter; expired_o flags the last cycle of the loaded window.
module sd_xfer_timeout #(
  parameter int TMO_W = 20
) (
  input  logic             sd_clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [TMO_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Next count: reload wins, otherwise count down to zero while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMO_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A window loaded with N expires on its N-th enabled cycle.
  assign expired_o = en_i && (cnt_q == TMO_W'(1));

endmodule

// File: rtl/sd_data_xfer_ctrl.sv
// Multi-block SD data transfer sequencer: arms the PHY per block, checks
// block status, waits out card busy and reports completion to the host.
module sd_data_xfer_ctrl
  import sd_xfer_pkg::*;
#(
  parameter int               BLK_CNT_W  = 8,
  parameter int               TMO_W      = 20,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 20'hFFFFF
) (
  input  logic                  sd_clk,
  input  logic                  rst,
  sd_data_xfer_ctrl_if.slave    host,
  output logic [1:0]            start_dat,
  output logic                  fifo_acces,
  input  logic                  tx_fifo_empty,
  input  logic                  rx_fifo_full,
  input  logic                  phy_done,
  input  logic                  wr_token_valid,
  input  logic [2:0]            wr_token,
  input  logic                  rd_crc_ok,
  input  logic                  dat0_i
);

  xfer_state_e          state_q, state_d;
  logic                 dir_q, dir_d;
  logic [BLK_CNT_W-1:0] remaining_q, remaining_d;
  logic [BLK_CNT_W-1:0] blocks_done_q, blocks_done_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 tok_seen_q, tok_seen_d;
  logic                 tok_bad_q, tok_bad_d;
  logic [1:0]           start_dat_q, start_dat_d;
  logic                 fifo_acces_q, fifo_acces_d;
  logic                 req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dat0_s1_q, dat0_s2_q;
  logic                 tmo_load, tmo_en, tmo_expired;
  logic                 abortable;

  // Timeout window runs in every state that waits on the outside world.
  assign tmo_en   = state_q inside {ST_ARM, ST_XFER, ST_BUSY_WAIT};
  assign tmo_load = (state_d != state_q) &&
                    (state_d inside {ST_ARM, ST_XFER, ST_BUSY_WAIT});

  sd_xfer_timeout #(.TMO_W(TMO_W)) u_tmo (
    .sd_clk     (sd_clk),
    .rst        (rst),
    .load_i     (tmo_load),
    .en_i       (tmo_en),
    .load_val_i (TMO_CYCLES),
    .expired_o  (tmo_expired)
  );

  // Abort applies to every active state except the stop/finish tail.
  assign abortable = state_q inside {ST_ARM, ST_START, ST_XFER, ST_BUSY_WAIT, ST_NEXT};

  // Next-state, per-transfer bookkeeping and registered-output decode.
  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no path can infer a latch.
    state_d       = state_q;
    dir_d         = dir_q;
    remaining_d   = remaining_q;
    blocks_done_d = blocks_done_q;
    err_d         = err_q;
    tok_seen_d    = tok_seen_q;
    tok_bad_d     = tok_bad_q;

    unique case (state_q)
      ST_IDLE: begin
        if (host.req_valid) begin
          dir_d         = host.req_dir;
          remaining_d   = (host.req_blocks == '0) ? BLK_CNT_W'(1) : host.req_blocks;
          err_d         = '0;
          blocks_done_d = '0;
          state_d       = ST_ARM;
        end
      end
      ST_ARM: begin
        if (dir_q ? !rx_fifo_full : !tx_fifo_empty) begin
          state_d = ST_START;
        end else if (tmo_expired) begin
          err_d[ERR_TMO] = 1'b1;
          state_d        = ST_STOP;
        end
      end
      ST_START: begin
        tok_seen_d = 1'b0;
        tok_bad_d  = 1'b0;
        state_d    = ST_XFER;
      end
      ST_XFER: begin
        // A token arriving with phy_done still counts for this block.
        if (wr_token_valid) begin
          tok_seen_d = 1'b1;
          tok_bad_d  = (wr_token != SD_TOKEN_OK);
        end
        if (phy_done) begin
          if (dir_q) begin
            if (!rd_crc_ok) begin
              err_d[ERR_CRC] = 1'b1;
              state_d        = ST_STOP;
            end else begin
              state_d = ST_NEXT;
            end
          end else if (!tok_seen_d || tok_bad_d) begin
            err_d[ERR_TOKEN] = 1'b1;
            state_d          = ST_STOP;
          end else begin
            state_d = ST_BUSY_WAIT;
          end
        end else if (tmo_expired) begin
          err_d[ERR_TMO] = 1'b1;
          state_d        = ST_STOP;
        end
      end
      ST_BUSY_WAIT: begin
        if (dat0_s2_q) begin
          state_d = ST_NEXT;
        end else if (tmo_expired) begin
          err_d[ERR_TMO] = 1'b1;
          state_d        = ST_STOP;
        end
      end
      ST_NEXT: begin
        blocks_done_d = (&blocks_done_q) ? blocks_done_q : blocks_done_q + BLK_CNT_W'(1);
        remaining_d   = (remaining_q != '0) ? remaining_q - BLK_CNT_W'(1) : '0;
        state_d       = (remaining_q <= BLK_CNT_W'(1)) ? ST_FIN : ST_ARM;
      end
      ST_STOP: state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything decided above, including a coincident phy_done.
    if (host.abort && abortable) begin
      state_d       = ST_STOP;
      err_d         = err_q;
      blocks_done_d = blocks_done_q;
      remaining_d   = remaining_q;
    end

    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_FIN);
    fifo_acces_d = (state_d == ST_XFER) && dir_d && !rx_fifo_full;
    start_dat_d  = SD_START_NONE;
    if (state_d == ST_START) begin
      start_dat_d = dir_d ? SD_START_RD : SD_START_WR;
    end else if (state_d == ST_STOP) begin
      start_dat_d = SD_START_STOP;
    end
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge sd_clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q       <= ST_IDLE;
      dir_q         <= 1'b0;
      remaining_q   <= '0;
      blocks_done_q <= '0;
      err_q         <= '0;
      tok_seen_q    <= 1'b0;
      tok_bad_q     <= 1'b0;
      start_dat_q   <= SD_START_NONE;
      fifo_acces_q  <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      remaining_q   <= remaining_d;
      blocks_done_q <= blocks_done_d;
      err_q         <= err_d;
      tok_seen_q    <= tok_seen_d;
      tok_bad_q     <= tok_bad_d;
      start_dat_q   <= start_dat_d;
      fifo_acces_q  <= fifo_acces_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Two-flop DAT0 synchroniser; resets to "not busy".
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      dat0_s1_q <= 1'b1;
      dat0_s2_q <= 1'b1;
    end else begin
      dat0_s1_q <= dat0_i;
      dat0_s2_q <= dat0_s1_q;
    end
  end

  assign start_dat        = start_dat_q;
  assign fifo_acces       = fifo_acces_q;
  assign host.req_ready   = req_ready_q;
  assign host.busy        = busy_q;
  assign host.done        = done_q;
  assign host.err         = err_q;
  assign host.blocks_done = blocks_done_q;

endmodule

// File: tb/tb_sd_data_xfer_ctrl.sv
// Self-checking bench: a scoreboard holds the expected completion of each
// request and is popped when the sequencer pulses done.
module tb_sd_data_xfer_ctrl;
  import sd_xfer_pkg::*;

  localparam int BLK_CNT_W = 8;

  logic       sd_clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_dat;
  logic       fifo_acces;
  logic       tx_fifo_empty = 1'b0;
  logic       rx_fifo_full = 1'b0;
  logic       phy_done = 1'b0;
  logic       wr_token_valid = 1'b0;
  logic [2:0] wr_token = 3'b000;
  logic       rd_crc_ok = 1'b1;
  logic       dat0_i = 1'b1;

  sd_data_xfer_ctrl_if #(.BLK_CNT_W(BLK_CNT_W)) host_if ();

  sd_data_xfer_ctrl #(
    .BLK_CNT_W  (BLK_CNT_W),
    .TMO_W      (20),
    .TMO_CYCLES (20'd100)
  ) dut (
    .sd_clk         (sd_clk),
    .rst            (rst),
    .host           (host_if),
    .start_dat      (start_dat),
    .fifo_acces     (fifo_acces),
    .tx_fifo_empty  (tx_fifo_empty),
    .rx_fifo_full   (rx_fifo_full),
    .phy_done       (phy_done),
    .wr_token_valid (wr_token_valid),
    .wr_token       (wr_token),
    .rd_crc_ok      (rd_crc_ok),
    .dat0_i         (dat0_i)
  );

  always #5 sd_clk = ~sd_clk;

  typedef struct {
    logic [2:0] err;
    logic [7:0] blocks;
    int         starts;
    int         stops;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   mon_starts = 0;
  int   mon_stops = 0;
  int   phy1_cyc = 0;
  int   start2_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge sd_clk);
    cyc++;
  end

  // Monitor: counts start/stop pulses per transfer and scores each done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sd_clk);
      if (rst) begin
        mon_starts = 0;
        mon_stops  = 0;
      end else begin
        if (start_dat == SD_START_WR || start_dat == SD_START_RD) mon_starts++;
        else if (start_dat == SD_START_STOP) mon_stops++;
        if (host_if.done) begin
          done_cnt++;
          if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("err", host_if.err, e.err);
            check("blocks_done", host_if.blocks_done, e.blocks);
            check("start_pulses", mon_starts, e.starts);
            check("stop_pulses", mon_stops, e.stops);
          end
          mon_starts = 0;
          mon_stops  = 0;
        end
      end
    end
  end

  task automatic wait_start(input bit dir, output int sc, output bit ok);
    ok = 1'b0;
    sc = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sd_clk);
      if (start_dat == SD_START_WR || start_dat == SD_START_RD) begin
        ok = 1'b1;
        sc = cyc;
        break;
      end
    end
    check("start_seen", ok, 1'b1);
    if (ok) check("start_code", start_dat, dir ? SD_START_RD : SD_START_WR);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge sd_clk);
    check("done_seen", done_cnt != d0, 1'b1);
  endtask

  task automatic send_req(input bit dir, input int blocks);
    @(posedge sd_clk); #1;
    host_if.req_valid  = 1'b1;
    host_if.req_dir    = dir;
    host_if.req_blocks = BLK_CNT_W'(blocks);
    @(posedge sd_clk); #1;
    host_if.req_valid  = 1'b0;
  endtask

  // One request with a PHY/card model; bad_blk / abort_blk are 1-based, 0 = none.
  task automatic do_xfer(input bit dir, input int blocks, input int bad_blk,
                         input logic [2:0] tok, input int abort_blk, input int busy_cyc);
    exp_t e;
    int   eff;
    int   d0;
    int   sc;
    bit   ok;
    eff      = (blocks == 0) ? 1 : blocks;
    e.err    = 3'b000;
    e.blocks = 8'(eff);
    e.starts = eff;
    e.stops  = 0;
    if (bad_blk > 0) begin
      e.err    = dir ? 3'b010 : 3'b001;
      e.blocks = 8'(bad_blk - 1);
      e.starts = bad_blk;
      e.stops  = 1;
    end else if (abort_blk > 0) begin
      e.blocks = 8'(abort_blk - 1);
      e.starts = abort_blk;
      e.stops  = 1;
    end
    sb.push_back(e);
    d0 = done_cnt;
    send_req(dir, blocks);
    for (int b = 1; b <= eff; b++) begin
      wait_start(dir, sc, ok);
      if (!ok) break;
      if (b == 2) start2_cyc = sc;
      repeat (3) @(posedge sd_clk); #1;
      if (!dir) begin
        wr_token_valid = 1'b1;
        wr_token       = (b == bad_blk) ? tok : SD_TOKEN_OK;
        dat0_i         = 1'b0;
        @(posedge sd_clk); #1;
        wr_token_valid = 1'b0;
        @(posedge sd_clk); #1;
      end
      phy_done      = 1'b1;
      rd_crc_ok     = (b != bad_blk);
      host_if.abort = (b == abort_blk);
      @(posedge sd_clk); #1;
      phy_done      = 1'b0;
      rd_crc_ok     = 1'b1;
      host_if.abort = 1'b0;
      if (b == 1) phy1_cyc = cyc;
      if (b == bad_blk || b == abort_blk) begin
        dat0_i = 1'b1;
        break;
      end
      if (!dir) begin
        repeat (busy_cyc) @(posedge sd_clk);
        #1 dat0_i = 1'b1;
      end
    end
    wait_done(d0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : stim
    int  sc;
    bit  ok;
    int  d0;
    int  t0;
    host_if.req_valid  = 1'b0;
    host_if.req_dir    = 1'b0;
    host_if.req_blocks = '0;
    host_if.abort      = 1'b0;

    // Reset values.
    repeat (3) @(negedge sd_clk);
    check("rst_req_ready", host_if.req_ready, 1'b1);
    check("rst_busy", host_if.busy, 1'b0);
    check("rst_done", host_if.done, 1'b0);
    check("rst_start_dat", start_dat, SD_START_NONE);
    check("rst_fifo_acces", fifo_acces, 1'b0);
    check("rst_err", host_if.err, 3'b000);
    check("rst_blocks_done", host_if.blocks_done, 8'd0);
    rst = 1'b0;
    // Abort in IDLE is ignored.
    @(posedge sd_clk); #1 host_if.abort = 1'b1;
    @(posedge sd_clk); #1 host_if.abort = 1'b0;
    @(negedge sd_clk);
    check("idle_abort_ready", host_if.req_ready, 1'b1);

    // Read, 3 blocks; NEXT, ARM, START after phy_done.
    do_xfer(1'b1, 3, 0, 3'b000, 0, 0);
    check("rd_phy_to_start", start2_cyc - phy1_cyc, 2);

    // Write, 2 blocks with 50 cycles of card busy.
    do_xfer(1'b0, 2, 0, 3'b000, 0, 50);
    check("wr_gap_ge_53", (start2_cyc - phy1_cyc) >= 53, 1'b1);

    // Bad CRC status token on block 1 of 4.
    do_xfer(1'b0, 4, 1, 3'b101, 0, 0);

    // Read CRC failure on block 2 of 3.
    do_xfer(1'b1, 3, 2, 3'b000, 0, 0);

    // RX FIFO full throughout: timeout in ARM.
    rx_fifo_full = 1'b1;
    sb.push_back('{err: 3'b100, blocks: 8'd0, starts: 0, stops: 1});
    d0 = done_cnt;
    send_req(1'b1, 2);
    t0 = cyc;
    wait_done(d0);
    check("tmo_elapsed_ge_100", (cyc - t0) >= 100, 1'b1);
    rx_fifo_full = 1'b0;

    // Abort coincident with phy_done on block 2 of 5.
    do_xfer(1'b1, 5, 0, 3'b000, 2, 0);

    // req_blocks = 0 transfers one block.
    do_xfer(1'b0, 0, 0, 3'b000, 0, 5);

    // Reset in the middle of a read XFER.
    send_req(1'b1, 3);
    wait_start(1'b1, sc, ok);
    repeat (3) @(posedge sd_clk); #1;
    phy_done = 1'b1;
    @(posedge sd_clk); #1;
    phy_done = 1'b0;
    wait_start(1'b1, sc, ok);
    @(posedge sd_clk);
    @(negedge sd_clk);
    check("pre_rst_fifo_acces", fifo_acces, 1'b1);
    check("pre_rst_blocks_done", host_if.blocks_done, 8'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req_ready", host_if.req_ready, 1'b1);
    check("mid_rst_busy", host_if.busy, 1'b0);
    check("mid_rst_start_dat", start_dat, SD_START_NONE);
    check("mid_rst_fifo_acces", fifo_acces, 1'b0);
    check("mid_rst_err", host_if.err, 3'b000);
    check("mid_rst_blocks_done", host_if.blocks_done, 8'd0);
    check("mid_rst_done", host_if.done, 1'b0);
    repeat (2) @(posedge sd_clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge sd_clk);
    check("post_rst_start_dat", start_dat, SD_START_NONE);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_data_xfer_ctrl.md
# sd_data_xfer_ctrl

Block-level sequencer for the 4-bit SD data PHY. It accepts multi-block read/write requests from the host-side register block and pulses the PHY start code once per block. It gates PHY FIFO access on buffer readiness, checks the per-block completion status (CRC status token on writes, CRC result on reads) and waits out card busy on DAT0 after writes. It reports completion, error cause and blocks transferred back to the register block.

## Interface
- BLK_CNT_W, 8, width of block count request and progress counter
- TMO_W, 20, width of timeout counter
- TMO_CYCLES, 20'hFFFFF, sd_clk cycles allowed per wait phase before timeout
- sd_clk  in  1  SD-side clock; all logic on posedge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  transfer request
- req_ready  out  1  high in IDLE only
- req_dir  in  1  0 = write to card, 1 = read from card
- req_blocks  in  BLK_CNT_W  number of blocks; 0 is treated as 1
- abort  in  1  host abort, sampled every cycle
- start_dat  out  2  PHY start code: 00 none, 01 write, 10 read, 11 stop
- fifo_acces  out  1  PHY permitted to move read data into RX FIFO
- tx_fifo_empty  in  1  host TX FIFO empty
- rx_fifo_full  in  1  host RX FIFO full
- phy_done  in  1  one-cycle pulse: PHY returned to idle after a block
- wr_token_valid  in  1  one-cycle pulse: CRC status token captured
- wr_token  in  3  CRC status token bits
- rd_crc_ok  in  1  read CRC result, valid with phy_done in read direction
- dat0_i  in  1  DAT0 line, low = card busy
- busy  out  1  transfer in progress (not IDLE)
- done  out  1  one-cycle completion pulse
- err  out  3  {timeout, crc, token}, valid with done, held until next accept
- blocks_done  out  BLK_CNT_W  blocks completed without error, cleared on accept

## Operation
- States: IDLE, ARM, START, XFER, BUSY_WAIT, NEXT, STOP, FIN.
- IDLE: req_ready=1. On req_valid, latch dir and remaining=max(req_blocks,1), clear err and blocks_done, go to ARM.
- ARM: write direction waits until !tx_fifo_empty; read direction waits until !rx_fifo_full. The timeout counter runs. Then go to START.
- START: drive start_dat=01 (write) or 10 (read) for exactly one cycle, then go to XFER.
- XFER: wait for phy_done. fifo_acces = dir & !rx_fifo_full.
  - Write: a wr_token_valid must precede phy_done. 3'b010 = good, anything else sets err[0]. Missing token at phy_done sets err[0].
  - Read: rd_crc_ok=0 at phy_done sets err[1].
  - No error: read goes to NEXT; write goes to BUSY_WAIT.
  - Error: go to STOP.
- BUSY_WAIT: wait for dat0_i high, synchronised through 2 flops, then go to NEXT.
- NEXT: increment blocks_done and decrement remaining. If remaining==0 go to FIN, else go to ARM.
- STOP: drive start_dat=11 for one cycle, then go to FIN.
- FIN: pulse done, go to IDLE.
- Timeout: a counter reloads on entering ARM, XFER and BUSY_WAIT. Expiry at TMO_CYCLES sets err[2] and goes to STOP.
- Abort: asserted in any non-IDLE state other than STOP or FIN, it goes to STOP with no err bit set. Ignored in IDLE.
- Width rules: blocks_done saturates at all-ones. remaining uses BLK_CNT_W bits; no wrap.

## Timing
- Reset values: state=IDLE, start_dat=00, fifo_acces=0, req_ready=1, busy=0, done=0, err=000, blocks_done=0; counters 0; dat0 sync flops=1.
- All outputs are registered.
- Request accept to START start_dat pulse: 2 cycles minimum (ARM with FIFO already ready).
- phy_done to next START, read direction: 3 cycles (NEXT, ARM, START).
- Write direction adds the BUSY_WAIT time plus the 2-cycle synchroniser latency.
- phy_done and abort in the same cycle: abort wins; the block is not counted.
- wr_token_valid and phy_done in the same cycle: the token is evaluated.
- Timeout expiry and phy_done in the same cycle: phy_done wins.
- Reset mid-transfer: immediate return to reset values; no stop code is issued.

## Structure
- Shared package sd_xfer_pkg holds:
  - state encoding
  - start code constants SD_START_NONE/WR/RD/STOP
  - token constant SD_TOKEN_OK=3'b010
  - err bit indices
- Sub-module sd_xfer_timeout: loadable down-counter with an expiry flag, reused later for the command path.

## Test plan
- Read, 3 blocks: rd_crc_ok=1 on each phy_done. Expect:
  - start_dat=10 three times
  - done with err=000, blocks_done=3
- Write, 2 blocks: token 010 each, dat0_i low for 50 cycles after each phy_done. Expect:
  - second start_dat=01 no earlier than 53 cycles after the first phy_done
  - blocks_done=2
- Write with token 101 on block 1 of 4. Expect start_dat=11 once, err=001, blocks_done=0.
- Read with rx_fifo_full held. Expect:
  - no start pulse
  - after TMO_CYCLES (set 100 in bench), err=100 and stop issued
- Abort coincident with phy_done on block 2 of 5. Expect err=000, blocks_done=1, stop issued, done pulses.
- req_blocks=0. Expect exactly one block transferred; reset asserted mid-XFER returns all outputs to reset values within the same cycle.
